// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, sells N priced drinks
// with per-drink stock, and hands the item and the change out over valid/ready.
module vend_ctrl #(
  parameter int                       N_DRINKS    = 4,
  parameter int                       CW          = 8,
  parameter logic [N_DRINKS*CW-1:0]   PRICES      = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                       MAX_CREDIT  = 100,
  parameter int                       STOCK_INIT  = 5,
  parameter bit                       AUTO_CHANGE = 1'b1,
  localparam int                      SW          = $clog2(N_DRINKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [CW-1:0]       coin,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [SW-1:0]       drink_choose,
  input  logic                restock,
  output logic                vend_valid,
  output logic [SW-1:0]       vend_id,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [CW-1:0]       change,
  input  logic                change_ready,
  output logic [CW-1:0]       total_coin,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [N_DRINKS-1:0] sold_out
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit, credit_nxt;
  logic [SW-1:0] vend_id_q, vend_id_nxt;
  logic          cancel_pend, cancel_pend_nxt;
  logic          coin_reject_q, coin_reject_nxt;
  logic          sel_err_q, sel_err_nxt;
  logic          sale;
  logic [7:0]    stock [N_DRINKS];

  logic [CW:0]   coin_sum;
  logic [CW-1:0] sel_price;
  logic          sel_in_stock;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      credit        <= '0;
      vend_id_q     <= '0;
      cancel_pend   <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      vend_id_q     <= vend_id_nxt;
      cancel_pend   <= cancel_pend_nxt;
      coin_reject_q <= coin_reject_nxt;
      sel_err_q     <= sel_err_nxt;
    end
  end

  // NOTE: the stock counters are real machine state, so unlike a data RAM
  // they must be reset; restock overrides a same-cycle sale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DRINKS; i++) stock[i] <= 8'(STOCK_INIT);
    end else begin
      for (int i = 0; i < N_DRINKS; i++) begin
        if (restock)
          stock[i] <= 8'(STOCK_INIT);
        else if (sale && drink_choose == SW'(i + 1))
          stock[i] <= stock[i] - 8'd1;
      end
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit;
    vend_id_nxt     = vend_id_q;
    cancel_pend_nxt = cancel_pend;
    coin_reject_nxt = coin_valid;
    sel_err_nxt     = 1'b0;
    sale            = 1'b0;
    coin_sum        = {1'b0, credit} + {1'b0, coin};
    sel_price       = '0;
    sel_in_stock    = 1'b0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (drink_choose == SW'(i + 1)) begin
        sel_price    = PRICES[i*CW +: CW];
        sel_in_stock = (stock[i] != 8'd0);
      end
    end

    unique case (state)
      IDLE: begin
        if (cancel) begin
          if (credit != '0) state_nxt = CHANGE;
        end else if (sel_valid) begin
          if (sel_in_stock && sel_price <= credit) begin
            credit_nxt  = credit - sel_price;
            vend_id_nxt = drink_choose;
            sale        = 1'b1;
            state_nxt   = VEND;
          end else begin
            sel_err_nxt = 1'b1;
          end
        end else if (coin_valid && coin_sum <= (CW+1)'(MAX_CREDIT)) begin
          credit_nxt      = coin_sum[CW-1:0];
          coin_reject_nxt = 1'b0;
        end
      end
      VEND: begin
        if (cancel) cancel_pend_nxt = 1'b1;
        if (vend_ready) begin
          // A cancel arriving on the handshake cycle still counts.
          state_nxt = ((AUTO_CHANGE || cancel_pend || cancel) && credit != '0)
                      ? CHANGE : IDLE;
          cancel_pend_nxt = 1'b0;
        end
      end
      CHANGE: begin
        if (change_ready) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vend_valid   = (state == VEND);
    change_valid = (state == CHANGE);
    change       = (state == CHANGE) ? credit : '0;
    vend_id      = vend_id_q;
    total_coin   = credit;
    coin_reject  = coin_reject_q;
    sel_err      = sel_err_q;
    sold_out     = '0;
    for (int i = 0; i < N_DRINKS; i++) sold_out[i] = (stock[i] == 8'd0);
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised, fully synchronous vending-machine controller, and the next generation of the coin/drink FSM. It accumulates credit from coin pulses and prices N drinks from a parameter vector. It tracks per-drink stock and presents the vended item and the change amount over valid/ready handshakes to the dispenser and coin-return blocks. It sits between the coin acceptor / keypad front end and the mechanical dispense and change units.

## Interface
- N_DRINKS, 4: number of drink ids; id 0 means "no choice", valid ids are 1..N_DRINKS.
- CW, 8: width of coin values, prices and credit.
- PRICES, {8'd25,8'd20,8'd15,8'd10}: packed N_DRINKS*CW vector; slice [i*CW +: CW] is the price of id i+1.
- MAX_CREDIT, 100: credit ceiling; must be < 2^CW.
- STOCK_INIT, 5: units per drink after reset/restock; 8-bit stock counters.
- AUTO_CHANGE, 1: 1 means return remaining credit after every vend; 0 means keep credit for further purchases.
- SW, derived: $clog2(N_DRINKS+1).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- coin_valid  in  1  one-cycle pulse, coin inserted.
- coin  in  CW  coin value, qualified by coin_valid.
- cancel  in  1  one-cycle pulse, refund request.
- sel_valid  in  1  one-cycle pulse, drink selected.
- drink_choose  in  SW  selected id.
- restock  in  1  one-cycle pulse, reload all stock counters.
- vend_valid  out  1  drink ready to dispense.
- vend_id  out  SW  drink being dispensed.
- vend_ready  in  1  dispenser accepts.
- change_valid  out  1  change to return.
- change  out  CW  change amount.
- change_ready  in  1  coin-return unit accepts.
- total_coin  out  CW  current credit.
- coin_reject  out  1  one-cycle pulse, coin refused (returned physically by acceptor).
- sel_err  out  1  one-cycle pulse, selection refused.
- sold_out  out  N_DRINKS  bit i high when stock of id i+1 is 0.

## Operation
- States: IDLE, VEND, CHANGE.
- IDLE priority per cycle: cancel > sel_valid > coin_valid. Any coin_valid not accepted pulses coin_reject.
- Cancel in IDLE: if credit > 0, go to CHANGE; if credit == 0, no-op and stay in IDLE.
- Selection in IDLE with id in 1..N, stock > 0 and price <= credit: credit -= price, stock[id] -= 1, vend_id <= id, go to VEND.
- Selection otherwise (id 0, id > N, sold out, or insufficient credit): sel_err pulse; state, credit and stock unchanged.
- Coin in IDLE: if credit + coin <= MAX_CREDIT, credit += coin; otherwise coin_reject and credit unchanged. Compute the sum at CW+1 bits so there is no wrap.
- VEND: vend_valid held with vend_id stable until vend_ready.
  - On handshake, go to CHANGE if (AUTO_CHANGE or cancel_pend) and credit > 0; else go to IDLE.
  - Coins in VEND are rejected.
  - A cancel in VEND sets cancel_pend. cancel_pend clears on leaving VEND.
- CHANGE: change_valid held with change = credit until change_ready. On handshake, credit <= 0 and go to IDLE.
  - Coins are rejected; cancel and sel_valid are ignored (no sel_err).
- restock, in any state: all stock counters <= STOCK_INIT. If it coincides with a sale decrement, restock wins.
- sold_out is combinational from the stock counters.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE; credit, vend_id, change 0.
  - vend_valid, change_valid, coin_reject, sel_err 0.
  - stock = STOCK_INIT; sold_out = 0 (all ones if STOCK_INIT == 0).
- Reset mid-VEND or mid-CHANGE aborts the transaction and drops credit; no handshake completes.
- Accepted coin: total_coin updates 1 cycle after the coin_valid edge.
- Accepted selection: vend_valid rises and total_coin drops 1 cycle later.
- vend_ready/change_ready may already be high when valid rises. Handshake completes on the first edge with valid && ready. Minimum VEND dwell is 1 cycle.
- The next state's valid asserts the cycle after the handshake. No combinational path from ready to valid.
- coin_reject and sel_err are registered; they appear 1 cycle after the offending pulse and last exactly 1 cycle.

## Test plan
- Coins 10, 5, 10 on separate cycles, then select id 3 (20), vend_ready held high -> total_coin 25; then vend_valid with vend_id 3; then change_valid with change 5; then IDLE with total_coin 0.
- AUTO_CHANGE=0: insert 25, buy id 1; then buy id 2 -> no change_valid; total_coin 15 then 0; stock[1] = stock[2] = 4.
- Insert 10, select id 4 (25) -> sel_err pulse, total_coin stays 10. Then cancel -> change 10, total_coin 0.
- Insert coins totalling 95, then coin 10 -> coin_reject, total_coin 95. Cancel and sel_valid asserted in the same cycle -> change 95, no vend.
- Buy id 1 five times -> sold_out[0] = 1, sixth buy gives sel_err. Restock -> sold_out[0] = 0.
- Assert reset while vend_valid is high and vend_ready is low -> all outputs return to reset values asynchronously, total_coin 0.
